// File: rtl/seg_scan_scheduler.sv
// Seven-segment scan scheduler: time-multiplexes the shared cathode bus across the digit
// anodes. It snapshots display data once per frame, blanks all anodes at the start of each
// digit slot, and PWM-gates the active anode for brightness.
module seg_scan_scheduler #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 200
) (
    input  logic                      CLK100MHZ,
    input  logic                      RESET_BTN,
    input  logic                      enable,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [7:0]                pwm_in,
    output logic [7:0]                SevenSegment,
    output logic [7:0]                SegmentDrivers,
    output logic                      frame_tick
);

    localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SlotW-1:0] SlotLast  = SlotW'(SCAN_DIV - 1);
    localparam logic [SlotW-1:0] BlankLast = SlotW'(BLANK_CYCLES - 1);
    localparam logic [IdxW-1:0]  IdxLast   = IdxW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

    state_e                  state_q, state_d;
    logic [SlotW-1:0]        slot_q, slot_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [7:0]              pwm_q, pwm_d;
    logic                    snap_take;

    logic [4*NUM_DIGITS-1:0] digits_snap_q;
    logic [NUM_DIGITS-1:0]   dp_snap_q;
    logic [7:0]              pwm_snap_q;

    logic [7:0]              ss_q, ss_d;
    logic [7:0]              sd_q, sd_d;
    logic                    ft_q;

    // Active-low a..g for a BCD digit; codes 10..15 blank the digit.
    function automatic logic [6:0] decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    // Scan sequencing: slot counter, digit index, PWM counter and frame snapshot request.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        idx_d     = idx_q;
        pwm_d     = pwm_q;
        snap_take = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            slot_d  = '0;
            idx_d   = '0;
            pwm_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // First slot after enable is also a frame start.
                    state_d   = StBlank;
                    slot_d    = '0;
                    idx_d     = '0;
                    pwm_d     = '0;
                    snap_take = 1'b1;
                end
                StBlank: begin
                    pwm_d  = pwm_q + 8'd1;
                    slot_d = slot_q + 1'b1;
                    if (slot_q == BlankLast) begin
                        state_d = StDrive;
                    end
                end
                StDrive: begin
                    pwm_d = pwm_q + 8'd1;
                    if (slot_q == SlotLast) begin
                        slot_d  = '0;
                        state_d = StBlank;
                        if (idx_q == IdxLast) begin
                            idx_d     = '0;
                            snap_take = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Pin values from the current scan position; registered below so pins lag by one cycle.
    always_comb begin
        logic [3:0] nib;
        logic       dp_bit;
        nib    = 4'hF;
        dp_bit = 1'b0;
        ss_d   = 8'hFF;
        sd_d   = 8'hFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                nib    = digits_snap_q[i*4 +: 4];
                dp_bit = dp_snap_q[i];
            end
        end
        if (enable && (state_q != StIdle)) begin
            ss_d = {~dp_bit, decode(nib)};
            if ((state_q == StDrive) && ((pwm_q < pwm_snap_q) || (pwm_snap_q == 8'hFF))) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        sd_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    // State, snapshot and output registers with synchronous active-low reset.
    always_ff @(posedge CLK100MHZ) begin
        if (!RESET_BTN) begin
            state_q       <= StIdle;
            slot_q        <= '0;
            idx_q         <= '0;
            pwm_q         <= '0;
            digits_snap_q <= '0;
            dp_snap_q     <= '0;
            pwm_snap_q    <= '0;
            ss_q          <= 8'hFF;
            sd_q          <= 8'hFF;
            ft_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            pwm_q   <= pwm_d;
            ss_q    <= ss_d;
            sd_q    <= sd_d;
            ft_q    <= snap_take;
            if (snap_take) begin
                digits_snap_q <= digits;
                dp_snap_q     <= dp;
                pwm_snap_q    <= pwm_in;
            end
        end
    end

    assign SevenSegment   = ss_q;
    assign SegmentDrivers = sd_q;
    assign frame_tick     = ft_q;

endmodule
